// File: rtl/threshold_mask.sv
// threshold_mask: RGB565 to 1-bit object mask, fixed 2-cycle pipeline.
// Define THRESHOLD_MASK_RUN_FILTER_EN to enable the stage-2 run filter.
module threshold_mask #(
  parameter int HWIDTH      = 11,
  parameter int VWIDTH      = 10,
  parameter int GRAY_TH_RST = 10,
  parameter int DARK_TH_RST = 5,
  parameter int MIN_RUN_RST = 1,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [HWIDTH-1:0]    hcount_in,
  input  logic [VWIDTH-1:0]    vcount_in,
  input  logic                 data_valid_in,
  input  logic [15:0]          pixel_in,
  input  logic                 cfg_we_in,
  input  logic [1:0]           cfg_addr_in,
  input  logic [5:0]           cfg_data_in,
  output logic                 pixel_out,
  output logic [HWIDTH-1:0]    hcount_out,
  output logic [VWIDTH-1:0]    vcount_out,
  output logic                 data_valid_out,
  output logic [CNT_WIDTH-1:0] frame_count_out
);

  logic [5:0] gray_th_q, gray_th_d;
  logic [5:0] dark_th_q, dark_th_d;
  logic [5:0] min_run_q, min_run_d;
  logic       invert_q, invert_d;

  always_comb begin
    gray_th_d = gray_th_q;
    dark_th_d = dark_th_q;
    min_run_d = min_run_q;
    invert_d  = invert_q;
    if (cfg_we_in) begin
      case (cfg_addr_in)
        2'd0:    gray_th_d = cfg_data_in;
        2'd1:    dark_th_d = cfg_data_in;
        2'd2:    invert_d  = cfg_data_in[0];
        default: min_run_d = cfg_data_in;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gray_th_q <= 6'(GRAY_TH_RST);
      dark_th_q <= 6'(DARK_TH_RST);
      min_run_q <= 6'(MIN_RUN_RST);
      invert_q  <= 1'b0;
    end else begin
      gray_th_q <= gray_th_d;
      dark_th_q <= dark_th_d;
      min_run_q <= min_run_d;
      invert_q  <= invert_d;
    end
  end

  // Stage 1: classify
  logic [5:0] r6, g6, b6;
  logic       dark;
  logic       cls_d, cls_s1_q;
  logic       vld_s1_q;
  logic [HWIDTH-1:0] h_s1_q;
  logic [VWIDTH-1:0] v_s1_q;

  always_comb begin
    r6    = {1'b0, pixel_in[15:11]};
    g6    = pixel_in[10:5];
    b6    = {1'b0, pixel_in[4:0]};
    dark  = (r6 <= gray_th_q && g6 <= gray_th_q && b6 <= gray_th_q)
         || (r6 <= dark_th_q && g6 <= gray_th_q)
         || (g6 <= gray_th_q && b6 <= dark_th_q)
         || (b6 <= dark_th_q && r6 <= dark_th_q);
    cls_d = (dark ^ invert_q) & data_valid_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cls_s1_q <= 1'b0;
      vld_s1_q <= 1'b0;
      h_s1_q   <= '0;
      v_s1_q   <= '0;
    end else begin
      cls_s1_q <= cls_d;
      vld_s1_q <= data_valid_in;
      h_s1_q   <= hcount_in;
      v_s1_q   <= vcount_in;
    end
  end

  // Stage 2: run filter or plain register
  logic pix_d, pix_q;

`ifdef THRESHOLD_MASK_RUN_FILTER_EN
  logic [5:0] run_q, run_d;

  always_comb begin
    run_d = run_q;
    if (vld_s1_q) begin
      if (h_s1_q == '0)
        run_d = {5'd0, cls_s1_q};
      else if (cls_s1_q)
        run_d = (run_q == 6'd63) ? run_q : run_q + 6'd1;
      else
        run_d = '0;
    end
    pix_d = cls_s1_q && (run_d >= min_run_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) run_q <= '0;
    else        run_q <= run_d;
  end
`else
  logic min_run_unused;
  assign min_run_unused = ^min_run_q;

  always_comb begin
    pix_d = cls_s1_q;
  end
`endif

  logic              vld_q;
  logic [HWIDTH-1:0] h_q;
  logic [VWIDTH-1:0] v_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_q <= 1'b0;
      vld_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      pix_q <= pix_d;
      vld_q <= vld_s1_q;
      h_q   <= h_s1_q;
      v_q   <= v_s1_q;
    end
  end

  // Frame counter works on the pipeline outputs
  logic                 frame_start;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] fc_q, fc_d;

  always_comb begin
    frame_start = vld_q && (h_q == '0) && (v_q == '0);
    acc_d = acc_q;
    fc_d  = fc_q;
    if (frame_start) begin
      fc_d  = acc_q;
      acc_d = {{(CNT_WIDTH-1){1'b0}}, pix_q};
    end else if (vld_q && pix_q && acc_q != {CNT_WIDTH{1'b1}}) begin
      acc_d = acc_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q <= '0;
      fc_q  <= '0;
    end else begin
      acc_q <= acc_d;
      fc_q  <= fc_d;
    end
  end

  assign pixel_out       = pix_q;
  assign hcount_out      = h_q;
  assign vcount_out      = v_q;
  assign data_valid_out  = vld_q;
  assign frame_count_out = fc_q;

endmodule
